// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
// funct3 encodings, the controller state enum and the alignment/lane helpers.
package lsu_pkg;

    localparam int unsigned LSU_XLEN  = 32;
    localparam int unsigned LSU_NLANE = LSU_XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Byte-lane write mask for an access of size funct3[1:0] at byte offset off.
    function automatic logic [LSU_NLANE-1:0] lane_mask(input logic [2:0] funct3,
                                                       input logic [1:0] off);
        logic [LSU_NLANE-1:0] m;
        case (funct3[1:0])
            2'b00:   m = LSU_NLANE'(1) << off;
            2'b01:   m = LSU_NLANE'(3) << off;
            default: m = '1;
        endcase
        return m;
    endfunction

    // Natural alignment: bytes anywhere, halves on even, words on 4-byte boundaries.
    function automatic logic is_aligned(input logic [2:0] funct3,
                                        input logic [1:0] addr);
        logic ok;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~addr[0];
            2'b10:   ok = (addr == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Loads accept signed and unsigned byte/half plus word; stores only B/H/W.
    function automatic logic is_legal(input logic load, input logic [2:0] funct3);
        logic ok;
        if (load) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational store lane steering/replication and load
// lane extraction with sign or zero extension.
module lsu_align #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NLANE = XLEN / 8
) (
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       off_i,
    input  logic [XLEN-1:0]  st_data_i,
    input  logic [XLEN-1:0]  ld_word_i,
    output logic [NLANE-1:0] we_o,
    output logic [XLEN-1:0]  st_data_o,
    output logic [XLEN-1:0]  ld_data_o
);
    import lsu_pkg::*;

    // Store side: lane enables and replicated write data.
    always_comb begin
        we_o = NLANE'(lane_mask(funct3_i, off_i));
        case (funct3_i[1:0])
            2'b00:   st_data_o = {NLANE{st_data_i[7:0]}};
            2'b01:   st_data_o = {(NLANE / 2){st_data_i[15:0]}};
            default: st_data_o = st_data_i;
        endcase
    end

    // Load side: pick the addressed lane, then extend per funct3[2].
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = ld_word_i[{off_i, 3'b000} +: 8];
        h = ld_word_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i[1:0])
            2'b00:   ld_data_o = funct3_i[2] ? {{(XLEN-8){1'b0}}, b}
                                             : {{(XLEN-8){b[7]}}, b};
            2'b01:   ld_data_o = funct3_i[2] ? {{(XLEN-16){1'b0}}, h}
                                             : {{(XLEN-16){h[15]}}, h};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store unit driving a req/gnt/rvalid data memory port.
// Optional memory timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NLANE    = XLEN / 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic [2:0]       req_funct3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_misalign,
    output logic             rsp_timeout,
    output logic             mem_req,
    output logic [NLANE-1:0] mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata
);
    import lsu_pkg::*;

    if (MAX_WAIT == 0) begin : g_bad_max_wait
        $error("lsu_mem_ctrl: MAX_WAIT must be at least 1");
    end

    lsu_state_e        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              load_q, load_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              misalign_q, misalign_d;

    logic [NLANE-1:0]  al_we;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ldata;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(MAX_WAIT + 1);
    logic [TW-1:0]     timer_q, timer_d;
    logic              timeout_q, timeout_d;
`endif

    lsu_align #(
        .XLEN  (XLEN),
        .NLANE (NLANE)
    ) u_align (
        .funct3_i  (funct3_q),
        .off_i     (addr_q[1:0]),
        .st_data_i (wdata_q),
        .ld_word_i (mem_rdata),
        .we_o      (al_we),
        .st_data_o (al_wdata),
        .ld_data_o (al_ldata)
    );

    // Next-state and captured request/response fields.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        load_d     = load_q;
        rsp_data_d = rsp_data_q;
        misalign_d = misalign_q;
`ifdef LSU_TIMEOUT_EN
        timer_d    = timer_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    funct3_d   = req_funct3;
                    load_d     = req_load;
                    rsp_data_d = '0;
`ifdef LSU_TIMEOUT_EN
                    timer_d    = '0;
                    timeout_d  = 1'b0;
`endif
                    if (is_legal(req_load, req_funct3) &&
                        is_aligned(req_funct3, req_addr[1:0])) begin
                        misalign_d = 1'b0;
                        state_d    = ISSUE;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ISSUE: begin
                // rvalid is deliberately not looked at here: grant comes first.
                if (mem_gnt) begin
                    state_d = load_q ? WAIT : RESP;
                end
`ifdef LSU_TIMEOUT_EN
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(MAX_WAIT - 1)) begin
                    state_d   = RESP;
                    timeout_d = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rsp_data_d = al_ldata;
                    state_d    = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(MAX_WAIT - 1)) begin
                    rsp_data_d = '0;
                    state_d    = RESP;
                    timeout_d  = 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            load_q     <= 1'b0;
            rsp_data_q <= '0;
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            timer_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            load_q     <= load_d;
            rsp_data_q <= rsp_data_d;
            misalign_q <= misalign_d;
`ifdef LSU_TIMEOUT_EN
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Port outputs decoded from the current state; flags only show during RESP.
    always_comb begin
        req_ready    = (state_q == IDLE);
        mem_req      = (state_q == ISSUE);
        mem_we       = (state_q == ISSUE && !load_q) ? al_we : '0;
        mem_addr     = {addr_q[XLEN-1:2], 2'b00};
        mem_wdata    = al_wdata;
        rsp_valid    = (state_q == RESP);
        rsp_data     = rsp_data_q;
        rsp_misalign = (state_q == RESP) && misalign_q;
`ifdef LSU_TIMEOUT_EN
        rsp_timeout  = (state_q == RESP) && timeout_q;
`else
        rsp_timeout  = 1'b0;
`endif
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit for the RV32I core; replaces the separate combinational L-type/S-type blocks.
- Accepts one load/store request per handshake from the execute stage and drives a data memory port with request/grant/rvalid handshaking.
- Produces byte-lane write enables, aligned store data and sign/zero-extended load data.
- Detects misaligned or illegal accesses and, optionally, memory timeouts.

Parameters:
- XLEN, 32, data and address width; must be a multiple of 8, only 32 is verified.
- NLANE, XLEN/8, byte lanes per word (derived; do not override).
- MAX_WAIT, 15, cycles spent in ISSUE+WAIT before timeout (requires LSU_TIMEOUT_EN).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request from execute stage
- req_ready  out  1  unit can accept a request
- req_load  in  1  1 = load, 0 = store
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  XLEN  byte address (rv1+imm)
- req_wdata  in  XLEN  store data (rv2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  XLEN  extended load result (0 for stores/errors)
- rsp_misalign  out  1  misaligned or illegal funct3, no memory access made
- rsp_timeout  out  1  memory did not grant/return within MAX_WAIT
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  NLANE  byte write enables (0 for loads)
- mem_addr  out  XLEN  word-aligned address (req_addr with low 2 bits cleared)
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  load word

Behaviour:
- Clocking and reset: clk, with a synchronous active-high reset.
- Reset values: state=IDLE; mem_req=0; mem_we=0; rsp_valid=0; rsp_data=0; rsp_misalign=0; rsp_timeout=0; timer=0. req_ready=1 from the first cycle after reset.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/funct3/wdata/load.
  - Alignment: byte always legal; half needs addr[0]=0; word needs addr[1:0]=0. funct3 of 011, 110 or 111 (and 1xx for stores) is illegal.
  - Misaligned/illegal -> RESP with misalign=1; otherwise -> ISSUE.
- ISSUE:
  - mem_req=1 with addr/we/wdata held stable.
  - On mem_gnt: store -> RESP; load -> WAIT.
  - Grant must be observed before rvalid is honoured.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: select the lane by addr[1:0], sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1), register into rsp_data, -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in every state except IDLE.
- Store lanes:
  - SB: we = 1 << addr[1:0]; wdata = byte replicated x4.
  - SH: we = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: we = 1111.
- Latency from the accepting edge:
  - store with immediate grant: rsp_valid two cycles later.
  - load with immediate grant and next-cycle rvalid: three cycles.
  - misaligned: one cycle.
- Boundary cases:
  - mem_rvalid outside WAIT is ignored.
  - A mem_gnt and mem_rvalid coincident in ISSUE counts as grant only.
  - Reset mid-transaction drops mem_req on the next edge and returns to IDLE; late rvalid is discarded.
  - Error flags are valid only with rsp_valid and are cleared to 0 otherwise.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - timer clears on entering ISSUE and increments each cycle in ISSUE/WAIT.
  - When the timer reaches MAX_WAIT: mem_req drops, -> RESP with rsp_timeout=1, rsp_data=0.
- Undefined: no timer logic; the unit waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state enum: IDLE, ISSUE, WAIT, RESP.
  - functions lane_mask(funct3, off) and is_aligned(funct3, addr).
- Sub-module lsu_align: purely combinational store lane/replication and load extract/extend; instantiated once.

Test Plan:
- SB addr=0x1003 wdata=0x000000A5, gnt immediate -> mem_addr=0x1000, mem_we=1000, mem_wdata=0xA5A5A5A5, rsp_valid two cycles after accept, misalign=0.
- LB addr=0x2002, rdata=0x00800000 -> rsp_data=0xFFFFFF80; same access as LBU -> 0x00000080.
- LH addr=0x2001 -> rsp_valid next cycle with misalign=1, mem_req never asserted; SW addr=0x2002 -> same.
- LW with mem_gnt held low 4 cycles, rvalid 2 cycles after grant, rdata=0xDEADBEEF -> rsp_data=0xDEADBEEF; req_ready=0 throughout; back-to-back request accepted the cycle after rsp_valid.
- LSU_TIMEOUT_EN, MAX_WAIT=15, gnt never -> mem_req drops and rsp_valid with rsp_timeout=1 at timer=15; without the macro the unit stays in ISSUE for 100 cycles.
- reset asserted in WAIT, then rvalid arrives in IDLE -> no rsp_valid, req_ready=1, mem_req=0.
